bus_interconnect: RTL and testbench



---
 rtl/bus_pkg.sv | 19 +
 rtl/bus_addr_decode.sv | 29 ++
 rtl/bus_interconnect.sv | 150 +++++++++++++++
 tb/tb_bus_interconnect.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus interconnect: select-width helper and response-source record.
package bus_pkg;

    localparam int SelW = 8;

    typedef logic [SelW-1:0] sel_t;

    typedef struct packed {
        sel_t host_sel;
        sel_t dev_sel;
        logic miss;
        logic pending;
    } rsp_src_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Base/mask address decoder; lowest matching device index wins, miss flags an unmapped address.
// Purely combinational, no backpressure.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int NrDevices    = 1,
    parameter int AddressWidth = 32,
    parameter int IdxW         = sel_width(NrDevices)
) (
    input  logic [AddressWidth-1:0] addr,
    input  logic [AddressWidth-1:0] base [NrDevices],
    input  logic [AddressWidth-1:0] mask [NrDevices],
    output logic [IdxW-1:0]         dev_idx,
    output logic                    miss
);

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        dev_idx = '0;
        miss    = 1'b1;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((addr & mask[d]) == base[d]) begin
                dev_idx = IdxW'(d);
                miss    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bus_interconnect.sv
// Multi-host/multi-device interconnect: fixed-priority arbiter, address decode, 1-cycle response routing.
// Grant is combinational; devices never stall. BUS_DECODE_ERR_EN makes unmapped accesses return an error.
module bus_interconnect
    import bus_pkg::*;
#(
    parameter int NrDevices    = 1,
    parameter int NrHosts      = 1,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      host_req_i    [NrHosts],
    output logic                      host_gnt_o    [NrHosts],
    input  logic [AddressWidth-1:0]   host_addr_i   [NrHosts],
    input  logic                      host_we_i     [NrHosts],
    input  logic [DataWidth/8-1:0]    host_be_i     [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i  [NrHosts],
    output logic                      host_rvalid_o [NrHosts],
    output logic [DataWidth-1:0]      host_rdata_o  [NrHosts],
    output logic                      host_err_o    [NrHosts],

    output logic                      device_req_o    [NrDevices],
    output logic [AddressWidth-1:0]   device_addr_o   [NrDevices],
    output logic                      device_we_o     [NrDevices],
    output logic [DataWidth/8-1:0]    device_be_o     [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o  [NrDevices],
    input  logic                      device_rvalid_i [NrDevices],
    input  logic [DataWidth-1:0]      device_rdata_i  [NrDevices],
    input  logic                      device_err_i    [NrDevices],

    input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

`ifdef BUS_DECODE_ERR_EN
    localparam bit DecodeErrEn = 1'b1;
`else
    localparam bit DecodeErrEn = 1'b0;
`endif

    localparam int DevSelW = sel_width(NrDevices);
    localparam int BeW     = DataWidth / 8;

    logic                    any_req;
    sel_t                    win_sel;
    logic [AddressWidth-1:0] win_addr;
    logic                    win_we;
    logic [BeW-1:0]          win_be;
    logic [DataWidth-1:0]    win_wdata;
    logic [DevSelW-1:0]      dev_idx;
    logic                    dec_miss;
    logic                    route_ok;
    rsp_src_t                rsp_q;

    // Fixed priority: the downward scan leaves the lowest requesting host selected.
    always_comb begin
        any_req   = 1'b0;
        win_sel   = '0;
        win_addr  = '0;
        win_we    = 1'b0;
        win_be    = '0;
        win_wdata = '0;
        for (int h = NrHosts - 1; h >= 0; h--) begin
            if (host_req_i[h]) begin
                any_req   = 1'b1;
                win_sel   = sel_t'(h);
                win_addr  = host_addr_i[h];
                win_we    = host_we_i[h];
                win_be    = host_be_i[h];
                win_wdata = host_wdata_i[h];
            end
        end
    end

    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            host_gnt_o[h] = any_req && (win_sel == sel_t'(h));
        end
    end

    bus_addr_decode #(
        .NrDevices    (NrDevices),
        .AddressWidth (AddressWidth),
        .IdxW         (DevSelW)
    ) u_decode (
        .addr    (win_addr),
        .base    (cfg_device_addr_base),
        .mask    (cfg_device_addr_mask),
        .dev_idx (dev_idx),
        .miss    (dec_miss)
    );

    // Without decode errors a miss leaves dev_idx at 0, so unmapped accesses fall to device 0.
    assign route_ok = any_req && !(dec_miss && DecodeErrEn);

    always_comb begin
        for (int d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = 1'b0;
            device_addr_o[d]  = '0;
            device_we_o[d]    = 1'b0;
            device_be_o[d]    = '0;
            device_wdata_o[d] = '0;
            if (route_ok && (dev_idx == DevSelW'(d))) begin
                device_req_o[d]   = 1'b1;
                device_addr_o[d]  = win_addr;
                device_we_o[d]    = win_we;
                device_be_o[d]    = win_be;
                device_wdata_o[d] = win_wdata;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_q <= '0;
        end else if (any_req) begin
            rsp_q <= '{host_sel: win_sel,
                       dev_sel:  sel_t'(dev_idx),
                       miss:     dec_miss,
                       pending:  1'b1};
        end else begin
            rsp_q.pending <= 1'b0;
        end
    end

    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            host_rvalid_o[h] = 1'b0;
            host_rdata_o[h]  = '0;
            host_err_o[h]    = 1'b0;
            if (rsp_q.pending && (rsp_q.host_sel == sel_t'(h))) begin
                if (rsp_q.miss && DecodeErrEn) begin
                    host_rvalid_o[h] = 1'b1;
                    host_err_o[h]    = 1'b1;
                end else begin
                    for (int d = 0; d < NrDevices; d++) begin
                        if (rsp_q.dev_sel == sel_t'(d)) begin
                            host_rvalid_o[h] = device_rvalid_i[d];
                            host_rdata_o[h]  = device_rdata_i[d];
                            host_err_o[h]    = device_err_i[d];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed bench for bus_interconnect with 2 hosts and 3 devices (RAM, SimCtrl, Timer).
// Expectations for unmapped accesses follow BUS_DECODE_ERR_EN.
module tb_bus_interconnect;

    localparam int NH = 2;
    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        rst;

    logic        host_req    [NH];
    logic        host_gnt    [NH];
    logic [31:0] host_addr   [NH];
    logic        host_we     [NH];
    logic [3:0]  host_be     [NH];
    logic [31:0] host_wdata  [NH];
    logic        host_rvalid [NH];
    logic [31:0] host_rdata  [NH];
    logic        host_err    [NH];

    logic        dev_req    [ND];
    logic [31:0] dev_addr   [ND];
    logic        dev_we     [ND];
    logic [3:0]  dev_be     [ND];
    logic [31:0] dev_wdata  [ND];
    logic        dev_rvalid [ND];
    logic [31:0] dev_rdata  [ND];
    logic        dev_err    [ND];
    logic [31:0] cfg_base   [ND];
    logic [31:0] cfg_mask   [ND];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_interconnect #(
        .NrDevices    (ND),
        .NrHosts      (NH),
        .DataWidth    (32),
        .AddressWidth (32)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .host_req_i           (host_req),
        .host_gnt_o           (host_gnt),
        .host_addr_i          (host_addr),
        .host_we_i            (host_we),
        .host_be_i            (host_be),
        .host_wdata_i         (host_wdata),
        .host_rvalid_o        (host_rvalid),
        .host_rdata_o         (host_rdata),
        .host_err_o           (host_err),
        .device_req_o         (dev_req),
        .device_addr_o        (dev_addr),
        .device_we_o          (dev_we),
        .device_be_o          (dev_be),
        .device_wdata_o       (dev_wdata),
        .device_rvalid_i      (dev_rvalid),
        .device_rdata_i       (dev_rdata),
        .device_err_i         (dev_err),
        .cfg_device_addr_base (cfg_base),
        .cfg_device_addr_mask (cfg_mask)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        for (int h = 0; h < NH; h++) begin
            host_req[h]   = 1'b0;
            host_addr[h]  = '0;
            host_we[h]    = 1'b0;
            host_be[h]    = '0;
            host_wdata[h] = '0;
        end
        for (int d = 0; d < ND; d++) begin
            dev_rvalid[d] = 1'b0;
            dev_rdata[d]  = '0;
            dev_err[d]    = 1'b0;
        end
    endtask

    task automatic next_step();
        @(posedge clk);
        #1;
        idle_all();
    endtask

    task automatic read0(input logic [31:0] a);
        host_req[0]  = 1'b1;
        host_addr[0] = a;
        host_be[0]   = 4'hF;
    endtask

    function automatic logic [2:0] reqs();
        return {dev_req[2], dev_req[1], dev_req[0]};
    endfunction

    initial begin
        rst = 1'b1;
        cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h000F_FFFF;
        cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
        cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;
        idle_all();
        @(posedge clk);
        #2;
        chk("reset_rvalid0", 64'(host_rvalid[0]), 64'd0);
        chk("reset_gnt_idle", {host_gnt[1], host_gnt[0]}, 64'd0);

        // Grant during reset is combinational but must not produce a response.
        next_step();
        read0(32'h0010_0000);
        #1;
        chk("reset_gnt_comb", 64'(host_gnt[0]), 64'd1);
        next_step();
        rst = 1'b0;
        dev_rvalid[0] = 1'b1;
        dev_rdata[0]  = 32'h1111_1111;
        #1;
        chk("post_reset_no_rvalid", 64'(host_rvalid[0]), 64'd0);

        // RAM read
        next_step();
        read0(32'h0010_0040);
        #1;
        chk("ram_gnt", {host_gnt[1], host_gnt[0]}, 64'b01);
        chk("ram_dev_req", 64'(reqs()), 64'b001);
        chk("ram_dev_addr", 64'(dev_addr[0]), 64'h0010_0040);
        next_step();
        dev_rvalid[0] = 1'b1;
        dev_rdata[0]  = 32'hDEAD_BEEF;
        // Back-to-back: SimCtrl write issued in the response cycle.
        host_req[0]   = 1'b1;
        host_addr[0]  = 32'h0002_0008;
        host_we[0]    = 1'b1;
        host_be[0]    = 4'h1;
        host_wdata[0] = 32'h41;
        #1;
        chk("ram_rvalid", 64'(host_rvalid[0]), 64'd1);
        chk("ram_rdata", 64'(host_rdata[0]), 64'hDEAD_BEEF);
        chk("ram_err", 64'(host_err[0]), 64'd0);
        chk("ram_rvalid_h1", 64'(host_rvalid[1]), 64'd0);
        chk("wr_dev_req", 64'(reqs()), 64'b010);
        chk("wr_we1", 64'(dev_we[1]), 64'd1);
        chk("wr_addr1", 64'(dev_addr[1]), 64'h0002_0008);
        chk("wr_wdata1", 64'(dev_wdata[1]), 64'h41);
        chk("wr_be1", 64'(dev_be[1]), 64'h1);
        chk("wr_dev0_zero", {dev_addr[0], dev_wdata[0]}, 64'd0);
        chk("wr_dev2_zero", {dev_addr[2], dev_wdata[2]}, 64'd0);
        chk("wr_dev_we_be_zero", {dev_we[0], dev_be[0], dev_we[2], dev_be[2]}, 64'd0);
        next_step();
        dev_rvalid[1] = 1'b1;
        #1;
        chk("wr_rvalid", 64'(host_rvalid[0]), 64'd1);
        chk("wr_err", 64'(host_err[0]), 64'd0);

        // Timer error response
        next_step();
        read0(32'h0003_0010);
        #1;
        chk("tmr_dev_req", 64'(reqs()), 64'b100);
        next_step();
        dev_rvalid[2] = 1'b1;
        dev_err[2]    = 1'b1;
        #1;
        chk("tmr_rvalid", 64'(host_rvalid[0]), 64'd1);
        chk("tmr_err", 64'(host_err[0]), 64'd1);

        // Unmapped address
        next_step();
        read0(32'h0005_0000);
        #1;
        chk("unm_gnt", 64'(host_gnt[0]), 64'd1);
`ifdef BUS_DECODE_ERR_EN
        chk("unm_dev_req", 64'(reqs()), 64'b000);
        next_step();
        #1;
        chk("unm_rvalid", 64'(host_rvalid[0]), 64'd1);
        chk("unm_err", 64'(host_err[0]), 64'd1);
        chk("unm_rdata", 64'(host_rdata[0]), 64'd0);
`else
        chk("unm_dev_req", 64'(reqs()), 64'b001);
        next_step();
        dev_rvalid[0] = 1'b1;
        dev_rdata[0]  = 32'h1234;
        #1;
        chk("unm_rvalid", 64'(host_rvalid[0]), 64'd1);
        chk("unm_rdata", 64'(host_rdata[0]), 64'h1234);
        chk("unm_err", 64'(host_err[0]), 64'd0);
`endif

        // Two hosts request together
        next_step();
        read0(32'h0010_0000);
        host_req[1]  = 1'b1;
        host_addr[1] = 32'h0002_0000;
        #1;
        chk("arb_gnt_first", {host_gnt[1], host_gnt[0]}, 64'b01);
        chk("arb_req_first", 64'(reqs()), 64'b001);
        next_step();
        host_req[1]   = 1'b1;
        host_addr[1]  = 32'h0002_0000;
        dev_rvalid[0] = 1'b1;
        dev_rdata[0]  = 32'hA0;
        #1;
        chk("arb_gnt_second", {host_gnt[1], host_gnt[0]}, 64'b10);
        chk("arb_req_second", 64'(reqs()), 64'b010);
        chk("arb_rsp_h0", {host_rvalid[1], host_rvalid[0]}, 64'b01);
        chk("arb_rdata_h0", 64'(host_rdata[0]), 64'hA0);
        next_step();
        dev_rvalid[1] = 1'b1;
        dev_rdata[1]  = 32'hB1;
        #1;
        chk("arb_rsp_h1", {host_rvalid[1], host_rvalid[0]}, 64'b10);
        chk("arb_rdata_h1", 64'(host_rdata[1]), 64'hB1);

        // Reset in the cycle after a grant, with a request held through reset.
        next_step();
        read0(32'h0010_0000);
        next_step();
        rst = 1'b1;
        read0(32'h0010_0000);
        next_step();
        rst = 1'b0;
        dev_rvalid[0] = 1'b1;
        dev_rdata[0]  = 32'h55;
        #1;
        chk("rst_mid_no_rvalid", {host_rvalid[1], host_rvalid[0]}, 64'd0);

        // Back-to-back reads, one per cycle.
        for (int i = 0; i < 4; i++) begin
            next_step();
            if (i < 3) read0(32'h0010_0000 + 32'(4 * i));
            if (i > 0) begin
                dev_rvalid[0] = 1'b1;
                dev_rdata[0]  = 32'h1000 + 32'(i - 1);
            end
            #1;
            if (i < 3) chk("b2b_gnt", 64'(host_gnt[0]), 64'd1);
            if (i > 0) begin
                chk("b2b_rvalid", 64'(host_rvalid[0]), 64'd1);
                chk("b2b_rdata", 64'(host_rdata[0]), 64'h1000 + 64'(i - 1));
            end
        end
        next_step();
        #1;
        chk("final_idle", {host_rvalid[1], host_rvalid[0]}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
